// File: rtl/fpu_issue_controller.sv
// fpu_issue_controller: sequences one fixed-point request at a time into the FPU.
// It holds operands and operation stable, waits for the unit's ready and captures
// the result. The result and its destination tag then go to writeback over a
// valid/ready handshake. The unit is parked on FPU_ADD whenever no request is in
// flight, so its multi-cycle sequencers restart cleanly on every request.
// Optional feature macro: FPU_ISSUE_TIMEOUT_EN adds a WAIT timeout (MAX_WAIT cycles)
// that answers with rsp_error = 1 and rsp_result = 0.

`ifndef FPU_ADD
`define FPU_ADD  2'd0
`endif
`ifndef FPU_SUB
`define FPU_SUB  2'd1
`endif
`ifndef FPU_MUL
`define FPU_MUL  2'd2
`endif
`ifndef FPU_SQRT
`define FPU_SQRT 2'd3
`endif

module fpu_issue_controller #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned FBITS    = 10,
    parameter int unsigned TAG_W    = 5,
    parameter int unsigned MAX_WAIT = 63
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_operand_1,
    input  logic [WIDTH-1:0] req_operand_2,
    input  logic [TAG_W-1:0] req_tag,
    output logic [WIDTH-1:0] fpu_operand_1,
    output logic [WIDTH-1:0] fpu_operand_2,
    output logic [1:0]       fpu_operation,
    input  logic [WIDTH-1:0] fpu_result,
    input  logic             fpu_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_error
);

    // FBITS only documents the Q format; operands pass through untouched.
    if (FBITS >= WIDTH || MAX_WAIT == 0) begin : g_param_check
        $error("fpu_issue_controller: FBITS must be < WIDTH and MAX_WAIT must be > 0");
    end

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e state_q;

`ifdef FPU_ISSUE_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(MAX_WAIT + 1);

    logic [CntW-1:0] wait_cnt_q;
    logic            error_q;
`endif

    // Handshake outputs decode the state register only.
    assign req_ready = (state_q == StIdle);
    assign rsp_valid = (state_q == StResp);

`ifdef FPU_ISSUE_TIMEOUT_EN
    assign rsp_error = error_q;
`else
    assign rsp_error = 1'b0;
`endif

    // Request sequencing FSM with registered FPU drive and response registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            fpu_operation <= `FPU_ADD;
            fpu_operand_1 <= '0;
            fpu_operand_2 <= '0;
            rsp_result    <= '0;
            rsp_tag       <= '0;
`ifdef FPU_ISSUE_TIMEOUT_EN
            wait_cnt_q    <= '0;
            error_q       <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        fpu_operation <= req_op;
                        fpu_operand_1 <= req_operand_1;
                        fpu_operand_2 <= req_operand_2;
                        rsp_tag       <= req_tag;
                        state_q       <= StIssue;
                    end else begin
                        fpu_operation <= `FPU_ADD;
                    end
                end
                StIssue: begin
                    // fpu_ready may still reflect the previous operation here.
`ifdef FPU_ISSUE_TIMEOUT_EN
                    wait_cnt_q <= '0;
`endif
                    state_q <= StWait;
                end
                StWait: begin
                    if (fpu_ready) begin
                        rsp_result    <= fpu_result;
                        fpu_operation <= `FPU_ADD;
                        state_q       <= StResp;
`ifdef FPU_ISSUE_TIMEOUT_EN
                        error_q       <= 1'b0;
                    end else if (wait_cnt_q + CntW'(1) == CntW'(MAX_WAIT)) begin
                        // The counter reaches MAX_WAIT on this edge: give up.
                        wait_cnt_q    <= wait_cnt_q + CntW'(1);
                        rsp_result    <= '0;
                        error_q       <= 1'b1;
                        fpu_operation <= `FPU_ADD;
                        state_q       <= StResp;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CntW'(1);
`endif
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/fpu_issue_controller.md
Name: fpu_issue_controller

Overview:
Sequencing stage directly upstream of the fixed-point unit. It accepts one fixed-point request at a time from the execute pipeline over a valid/ready handshake and holds operands and operation stable on the unit's inputs. It waits for the unit's ready, captures the result, and presents it with its destination tag to writeback over a second valid/ready handshake. Between requests it parks the unit on FPU_ADD, so the unit's multi-cycle multiply/sqrt sequencers restart cleanly on every request.

Parameters:
WIDTH, 32, operand/result width (Q format, matches the FPU)
FBITS, 10, fractional bits (documentation only, no arithmetic here)
TAG_W, 5, destination register tag width
MAX_WAIT, 63, timeout limit in WAIT cycles (used only with FPU_ISSUE_TIMEOUT_EN)

Ports:
clk  in  1  clock, all state updates on posedge
reset  in  1  asynchronous, active-high
req_valid  in  1  request present
req_ready  out  1  controller can accept
req_op  in  2  operation code, `FPU_ADD/`FPU_SUB/`FPU_MUL/`FPU_SQRT from Defines.vh
req_operand_1  in  WIDTH  first operand
req_operand_2  in  WIDTH  second operand (ignored for SQRT but still registered)
req_tag  in  TAG_W  destination tag
fpu_operand_1  out  WIDTH  to FPU operand_1
fpu_operand_2  out  WIDTH  to FPU operand_2
fpu_operation  out  2  to FPU operation
fpu_result  in  WIDTH  from FPU result
fpu_ready  in  1  from FPU ready
rsp_valid  out  1  result present
rsp_ready  in  1  writeback accepts
rsp_result  out  WIDTH  captured result
rsp_tag  out  TAG_W  tag of the request
rsp_error  out  1  timeout flag (0 unless feature enabled)

Behaviour:
- Clock is clk. Reset is asynchronous and active-high.
- All outputs are registered or decoded from the state register only. There is no combinational path from any input to any output.
- Reset values:
  - state = IDLE, so req_ready = 1 and rsp_valid = 0.
  - fpu_operation = `FPU_ADD.
  - fpu_operand_1 = fpu_operand_2 = 0.
  - rsp_result = 0, rsp_tag = 0, rsp_error = 0.
  - Wait counter = 0.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready = 1, and req_ready is 1 only in IDLE.
  - On an edge with req_valid = 1, register req_op into fpu_operation, the operands into fpu_operand_*, and the tag. Go to ISSUE.
  - Otherwise hold fpu_operation = `FPU_ADD.
- ISSUE:
  - Lasts exactly one cycle. fpu_ready is ignored because it may be stale from the previous operation.
  - Clear the wait counter. Go to WAIT.
- WAIT:
  - Operands and operation stay constant.
  - On an edge with fpu_ready = 1:
    - rsp_result <= fpu_result, rsp_error <= 0.
    - fpu_operation <= `FPU_ADD, which parks the unit.
    - Go to RESP.
  - Otherwise the wait counter increments.
- RESP:
  - rsp_valid = 1, with rsp_result, rsp_tag and rsp_error stable until accepted.
  - On an edge with rsp_ready = 1, go to IDLE.
  - A new request cannot be accepted in the same cycle; the earliest accept is the next IDLE cycle.
- Latency:
  - Request accepted at edge E0 gives ISSUE after E0, WAIT after E1, and capture at the first edge in WAIT with fpu_ready = 1.
  - ADD/SUB: capture at E2, rsp_valid high after E2.
  - Throughput: at most one request per 4 cycles.
- Operands pass through unmodified; the block performs no arithmetic and no width changes.
- rsp_ready held high while not in RESP has no effect.
- req_valid dropping while not in IDLE has no effect, since the request was already captured.
- Reset mid-operation: immediate return to IDLE with the reset values above. The in-flight request is discarded and no response is produced.

Optional Feature:
FPU_ISSUE_TIMEOUT_EN
- Defined: in WAIT, when the wait counter reaches MAX_WAIT with fpu_ready still 0:
  - rsp_result <= 0, rsp_error <= 1.
  - fpu_operation <= `FPU_ADD.
  - Go to RESP.
- Not defined: no counter is built, WAIT lasts indefinitely, rsp_error is tied to 0.

Test Plan:
- Reset, then ADD 1536 + 512 (1.5 + 0.5), with the FPU model asserting ready combinationally -> req_ready low for 3 cycles, rsp_valid after E2, rsp_result = 2048, rsp_tag echoed.
- MUL 1536 × 2048 (1.5 × 2.0) with a model asserting ready 6 cycles later -> fpu_operation = `FPU_MUL held throughout WAIT, rsp_result = 3072, and fpu_operation = `FPU_ADD from the cycle after capture.
- SQRT 4096 (4.0) followed immediately by SUB 1024 − 3072 -> first rsp 2048; second rsp 0xFFFFF800; stale ready from SQRT not sampled during the SUB's ISSUE.
- Hold rsp_ready = 0 for 10 cycles in RESP while asserting req_valid -> rsp_* stable, req_ready = 0, no second request accepted; accepted one cycle after rsp_ready rises.
- Assert reset in WAIT of a MUL -> state IDLE and outputs at reset values immediately (asynchronously), with no rsp_valid afterwards.
- With FPU_ISSUE_TIMEOUT_EN and MAX_WAIT = 63, fpu_ready stuck at 0 -> RESP after 63 WAIT cycles with rsp_error = 1 and rsp_result = 0.
- Without FPU_ISSUE_TIMEOUT_EN, fpu_ready stuck at 0 -> still in WAIT after 200 cycles.
